spmv_mc_adapter: RTL and testbench

- Sits directly downstream of one spmv_pe, on its req_mem_*/rsp_mem_* ports, and drives one Convey memory-controller (MC) port.
- Buffers PE requests and converts them to MC request format, carrying the PE 3-bit tag in rtnctl.
- Returns read data to the PE with the tag restored, using credit-based flow control so read data is never dropped.
- Tracks outstanding loads and stores and produces an idle flag for the quiesce logic.

---
 rtl/spmv_mc_adapter_pkg.sv | 31 +++
 rtl/std_fifo.sv | 57 +++++
 rtl/spmv_mc_adapter.sv | 191 +++++++++++++++++++
 tb/tb_spmv_mc_adapter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmv_mc_adapter_pkg.sv
// Shared definitions for the SpMV PE <-> Convey MC adapter.
// Holds the MC response command codes, the fixed MC request size, the
// request/response buffer entry layouts and the load rdctl encoder.
package spmv_mc_adapter_pkg;

  typedef enum logic [2:0] {
    MC_RSP_RDATA = 3'd2,
    MC_RSP_WRCMP = 3'd3
  } mc_rsp_cmd_e;

  localparam logic [1:0] MC_SIZE_8B = 2'd3;

  // Request FIFO entry: bit 112 = store flag, [111:64] = address, [63:0] = data/tag
  typedef struct packed {
    logic        st;
    logic [47:0] addr;
    logic [63:0] data;
  } req_entry_t;

  // Response FIFO entry: PE tag recovered from rdctl plus read data
  typedef struct packed {
    logic [2:0]  tag;
    logic [63:0] data;
  } rsp_entry_t;

  // Loads carry only the PE tag to the MC; everything else in rdctl is zero
  function automatic logic [63:0] load_rdctl(input logic [2:0] tag);
    return {61'b0, tag};
  endfunction

endpackage

// File: rtl/std_fifo.sv
// Generic synchronous FIFO with show-ahead output.
// Ports: clk/rst (sync, active-high flush), push/din write side,
// pop/dout read side (dout is the current head), empty/full flags and
// the occupancy count. Pushes when full and pops when empty are ignored.
module std_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int unsigned    AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]  LAST     = AW'(DEPTH - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spmv_mc_adapter.sv
// Adapter between one spmv_pe memory port and one Convey MC port.
// PE side:  pe_req_* (ld/st/addr/d_or_tag in, registered stall out),
//           pe_rsp_* (push/tag/q out, stall in).
// MC side:  mc_req_* (ld/st/vadr/wrd_rdctl/size out, rd/wr queue stalls in),
//           mc_rsp_* (push/cmd/data/rdctl in, registered stall out).
// Status:   idle (nothing buffered or in flight), err (sticky protocol error).
// Loads are limited by a read-credit pool equal to the response FIFO depth,
// so returned read data always has a slot and is never dropped.
module spmv_mc_adapter #(
  parameter int unsigned REQ_DEPTH = 16,
  parameter int unsigned RSP_DEPTH = 32,
  parameter int unsigned SKID      = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pe_req_ld,
  input  logic        pe_req_st,
  input  logic [47:0] pe_req_addr,
  input  logic [63:0] pe_req_d_or_tag,
  output logic        pe_req_stall,
  output logic        pe_rsp_push,
  output logic [2:0]  pe_rsp_tag,
  output logic [63:0] pe_rsp_q,
  input  logic        pe_rsp_stall,
  output logic        mc_req_ld,
  output logic        mc_req_st,
  output logic [47:0] mc_req_vadr,
  output logic [63:0] mc_req_wrd_rdctl,
  output logic [1:0]  mc_req_size,
  input  logic        mc_rd_rq_stall,
  input  logic        mc_wr_rq_stall,
  input  logic        mc_rsp_push,
  input  logic [2:0]  mc_rsp_cmd,
  input  logic [63:0] mc_rsp_data,
  input  logic [31:0] mc_rsp_rdctl,
  output logic        mc_rsp_stall,
  output logic        idle,
  output logic        err
);
  import spmv_mc_adapter_pkg::*;

  localparam int unsigned        REQ_CW     = $clog2(REQ_DEPTH + 1);
  localparam int unsigned        RSP_CW     = $clog2(RSP_DEPTH + 1);
  localparam logic [REQ_CW-1:0]  REQ_THRESH = REQ_CW'(REQ_DEPTH - SKID);
  localparam logic [RSP_CW-1:0]  RSP_THRESH = RSP_CW'(RSP_DEPTH - 2);
  localparam logic [RSP_CW-1:0]  CREDITS    = RSP_CW'(RSP_DEPTH);

  req_entry_t        req_din;
  req_entry_t        req_head;
  logic              req_push;
  logic              req_pop;
  logic              req_empty;
  logic              req_full;
  logic [REQ_CW-1:0] req_count;

  rsp_entry_t        rsp_din;
  rsp_entry_t        rsp_head;
  logic              rsp_push;
  logic              rsp_pop;
  logic              rsp_empty;
  logic              rsp_full;
  logic [RSP_CW-1:0] rsp_count;

  logic [RSP_CW-1:0] rd_credits;
  logic [CNT_W-1:0]  st_outstanding;
  logic              pe_rsp_stall_q;
  logic              ld_issue;
  logic              st_issue;
  logic              is_rdata;
  logic              is_wrcmp;
  logic              st_dec;
  logic              err_set;
  logic              rdctl_unused;

  // When ld and st collide, st=1 makes the entry a store and the load is lost
  assign req_din  = '{st: pe_req_st, addr: pe_req_addr, data: pe_req_d_or_tag};
  assign req_push = pe_req_ld | pe_req_st;

  always_comb begin
    req_pop = 1'b0;
    if (!req_empty) begin
      if (req_head.st) req_pop = ~mc_wr_rq_stall;
      else             req_pop = ~mc_rd_rq_stall & (rd_credits != '0);
    end
  end

  assign ld_issue = req_pop & ~req_head.st;
  assign st_issue = req_pop &  req_head.st;

  std_fifo #(
    .WIDTH ($bits(req_entry_t)),
    .DEPTH (REQ_DEPTH),
    .CW    (REQ_CW)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_push),
    .din   (req_din),
    .pop   (req_pop),
    .dout  (req_head),
    .empty (req_empty),
    .full  (req_full),
    .count (req_count)
  );

  assign is_rdata = mc_rsp_push & (mc_rsp_cmd == MC_RSP_RDATA);
  assign is_wrcmp = mc_rsp_push & (mc_rsp_cmd == MC_RSP_WRCMP);
  assign rsp_push = is_rdata & ~rst;
  assign rsp_din  = '{tag: mc_rsp_rdctl[2:0], data: mc_rsp_data};
  assign rsp_pop  = ~rsp_empty & ~pe_rsp_stall_q;
  assign rdctl_unused = ^mc_rsp_rdctl[31:3];

  std_fifo #(
    .WIDTH ($bits(rsp_entry_t)),
    .DEPTH (RSP_DEPTH),
    .CW    (RSP_CW)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_push),
    .din   (rsp_din),
    .pop   (rsp_pop),
    .dout  (rsp_head),
    .empty (rsp_empty),
    .full  (rsp_full),
    .count (rsp_count)
  );

  assign st_dec  = is_wrcmp & (st_outstanding != '0);
  assign err_set = (pe_req_ld & pe_req_st)
                 | (req_push & req_full)
                 | (is_rdata & rsp_full)
                 | (is_wrcmp & (st_outstanding == '0))
                 | (mc_rsp_push & ~is_rdata & ~is_wrcmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_credits       <= CREDITS;
      st_outstanding   <= '0;
      pe_rsp_stall_q   <= 1'b0;
      err              <= 1'b0;
      pe_req_stall     <= 1'b0;
      mc_rsp_stall     <= 1'b0;
      mc_req_ld        <= 1'b0;
      mc_req_st        <= 1'b0;
      mc_req_vadr      <= '0;
      mc_req_wrd_rdctl <= '0;
      mc_req_size      <= '0;
      pe_rsp_push      <= 1'b0;
      pe_rsp_tag       <= '0;
      pe_rsp_q         <= '0;
    end else begin
      pe_rsp_stall_q <= pe_rsp_stall;
      pe_req_stall   <= (req_count >= REQ_THRESH);
      mc_rsp_stall   <= (rsp_count >= RSP_THRESH);
      if (err_set) err <= 1'b1;

      // Credit return and load issue in the same cycle cancel out
      case ({rsp_pop, ld_issue})
        2'b10:   rd_credits <= rd_credits + 1'b1;
        2'b01:   rd_credits <= rd_credits - 1'b1;
        default: rd_credits <= rd_credits;
      endcase

      case ({st_issue, st_dec})
        2'b10:   if (st_outstanding != '1) st_outstanding <= st_outstanding + 1'b1;
        2'b01:   st_outstanding <= st_outstanding - 1'b1;
        default: st_outstanding <= st_outstanding;
      endcase

      mc_req_ld   <= ld_issue;
      mc_req_st   <= st_issue;
      mc_req_size <= MC_SIZE_8B;
      if (req_pop) begin
        mc_req_vadr      <= req_head.addr;
        mc_req_wrd_rdctl <= req_head.st ? req_head.data : load_rdctl(req_head.data[2:0]);
      end

      pe_rsp_push <= rsp_pop;
      if (rsp_pop) begin
        pe_rsp_tag <= rsp_head.tag;
        pe_rsp_q   <= rsp_head.data;
      end
    end
  end

  assign idle = req_empty & rsp_empty & (rd_credits == CREDITS) &
                (st_outstanding == '0) & ~mc_req_ld & ~mc_req_st & ~pe_rsp_push;

endmodule

// File: tb/tb_spmv_mc_adapter.sv
module tb_spmv_mc_adapter;

  localparam int RQ = 16;
  localparam int RD = 4;
  localparam int SK = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pe_req_ld = 1'b0, pe_req_st = 1'b0;
  logic [47:0] pe_req_addr = '0;
  logic [63:0] pe_req_d_or_tag = '0;
  logic        pe_req_stall;
  logic        pe_rsp_push;
  logic [2:0]  pe_rsp_tag;
  logic [63:0] pe_rsp_q;
  logic        pe_rsp_stall = 1'b0;
  logic        mc_req_ld, mc_req_st;
  logic [47:0] mc_req_vadr;
  logic [63:0] mc_req_wrd_rdctl;
  logic [1:0]  mc_req_size;
  logic        mc_rd_rq_stall = 1'b0, mc_wr_rq_stall = 1'b0;
  logic        mc_rsp_push = 1'b0;
  logic [2:0]  mc_rsp_cmd = '0;
  logic [63:0] mc_rsp_data = '0;
  logic [31:0] mc_rsp_rdctl = '0;
  logic        mc_rsp_stall;
  logic        idle, err;

  always #5 clk = ~clk;

  spmv_mc_adapter #(.REQ_DEPTH(RQ), .RSP_DEPTH(RD), .SKID(SK), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .pe_req_ld(pe_req_ld), .pe_req_st(pe_req_st), .pe_req_addr(pe_req_addr),
    .pe_req_d_or_tag(pe_req_d_or_tag), .pe_req_stall(pe_req_stall),
    .pe_rsp_push(pe_rsp_push), .pe_rsp_tag(pe_rsp_tag), .pe_rsp_q(pe_rsp_q),
    .pe_rsp_stall(pe_rsp_stall),
    .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st), .mc_req_vadr(mc_req_vadr),
    .mc_req_wrd_rdctl(mc_req_wrd_rdctl), .mc_req_size(mc_req_size),
    .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall),
    .mc_rsp_push(mc_rsp_push), .mc_rsp_cmd(mc_rsp_cmd), .mc_rsp_data(mc_rsp_data),
    .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_stall(mc_rsp_stall),
    .idle(idle), .err(err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { bit st; logic [47:0] addr; logic [63:0] data; } m_req_t;
  typedef struct { logic [2:0] tag; logic [63:0] data; } m_rsp_t;
  m_req_t m_req[$];
  m_rsp_t m_rsp[$];
  int  m_cred, m_stout;
  bit  m_err, m_stall_q, model_ok = 0;
  logic        e_ld, e_st, e_push, e_rqs, e_rss, e_idle;
  logic [47:0] e_vadr;
  logic [63:0] e_wrd, e_q;
  logic [2:0]  e_tag;

  always @(posedge clk) begin : model
    int qsz, rsz;
    bit pop, rpop;
    m_req_t h;
    m_req_t n;
    m_rsp_t r;
    if (rst) begin
      m_req.delete(); m_rsp.delete();
      m_cred = RD; m_stout = 0; m_err = 0; m_stall_q = 0;
      e_ld = 0; e_st = 0; e_push = 0; e_rqs = 0; e_rss = 0;
      model_ok = 1;
    end else begin
      qsz = m_req.size();
      rsz = m_rsp.size();
      e_rqs = (qsz >= RQ - SK);
      e_rss = (rsz >= RD - 2);
      pop = 0;
      if (qsz > 0) begin
        h = m_req[0];
        pop = h.st ? !mc_wr_rq_stall : (!mc_rd_rq_stall && m_cred > 0);
      end
      e_ld = pop && !h.st;
      e_st = pop && h.st;
      if (pop) begin
        e_vadr = h.addr;
        e_wrd  = h.st ? h.data : {61'b0, h.data[2:0]};
        void'(m_req.pop_front());
      end
      rpop = (rsz > 0) && !m_stall_q;
      e_push = rpop;
      if (rpop) begin
        e_tag = m_rsp[0].tag;
        e_q   = m_rsp[0].data;
        void'(m_rsp.pop_front());
      end
      m_stall_q = pe_rsp_stall;
      m_cred = m_cred + int'(rpop) - int'(e_ld);
      if (mc_rsp_push) begin
        if (mc_rsp_cmd == 3'd2) begin
          if (rsz == RD) m_err = 1;
          else begin r.tag = mc_rsp_rdctl[2:0]; r.data = mc_rsp_data; m_rsp.push_back(r); end
        end else if (mc_rsp_cmd == 3'd3) begin
          if (m_stout == 0) m_err = 1; else m_stout--;
        end else m_err = 1;
      end
      if (e_st && m_stout < 255) m_stout++;
      if (pe_req_ld || pe_req_st) begin
        if (pe_req_ld && pe_req_st) m_err = 1;
        if (qsz == RQ) m_err = 1;
        else begin
          n.st = pe_req_st; n.addr = pe_req_addr; n.data = pe_req_d_or_tag;
          m_req.push_back(n);
        end
      end
    end
    e_idle = (m_req.size() == 0) && (m_rsp.size() == 0) && (m_cred == RD) &&
             (m_stout == 0) && !e_ld && !e_st && !e_push;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("mc_req_ld", mc_req_ld, e_ld);
      chk("mc_req_st", mc_req_st, e_st);
      if (e_ld || e_st) begin
        chk("mc_req_vadr", mc_req_vadr, e_vadr);
        chk("mc_req_wrd_rdctl", mc_req_wrd_rdctl, e_wrd);
        chk("mc_req_size", mc_req_size, 2'd3);
      end
      chk("pe_rsp_push", pe_rsp_push, e_push);
      if (e_push) begin
        chk("pe_rsp_tag", pe_rsp_tag, e_tag);
        chk("pe_rsp_q", pe_rsp_q, e_q);
      end
      chk("pe_req_stall", pe_req_stall, e_rqs);
      chk("mc_rsp_stall", mc_rsp_stall, e_rss);
      chk("idle", idle, e_idle);
      chk("err", err, m_err);
    end
  end

  // ---------------- stimulus / MC responder ----------------
  typedef struct { bit st; logic [2:0] tag; logic [47:0] addr; } pend_t;
  pend_t pend[$];
  logic [2:0]  got_tag[$];
  logic [63:0] got_q[$];
  int cyc = 0, n_ld = 0, n_st = 0, n_rsp = 0, n_push = 0;
  int last_ld_cyc = 0, first_rsp_cyc = -1;
  bit auto_rsp = 0;

  function automatic logic [63:0] mkdata(input logic [47:0] a);
    return {16'hBEEF, a};
  endfunction

  task automatic send(input pend_t p);
    mc_rsp_push  = 1'b1;
    mc_rsp_cmd   = p.st ? 3'd3 : 3'd2;
    mc_rsp_rdctl = {29'b0, p.tag};
    mc_rsp_data  = p.st ? 64'h0 : mkdata(p.addr);
  endtask

  task automatic tick();
    pend_t p;
    int idx;
    @(posedge clk);
    #1;
    cyc++;
    if (mc_req_ld) begin
      p.st = 0; p.tag = mc_req_wrd_rdctl[2:0]; p.addr = mc_req_vadr;
      pend.push_back(p); n_ld++; last_ld_cyc = cyc;
    end
    if (mc_req_st) begin
      p.st = 1; p.tag = 3'd0; p.addr = mc_req_vadr;
      pend.push_back(p); n_st++;
    end
    if (pe_rsp_push) begin
      got_tag.push_back(pe_rsp_tag); got_q.push_back(pe_rsp_q); n_rsp++;
      if (first_rsp_cyc < 0) first_rsp_cyc = cyc;
    end
    pe_req_ld = 1'b0; pe_req_st = 1'b0;
    mc_rsp_push = 1'b0; mc_rsp_cmd = '0; mc_rsp_data = '0; mc_rsp_rdctl = '0;
    if (auto_rsp && pend.size() > 0 && $urandom_range(0, 1) == 0) begin
      idx = $urandom_range(0, pend.size() - 1);
      send(pend[idx]);
      pend.delete(idx);
    end
  endtask

  task automatic pe_load(input logic [47:0] a, input logic [2:0] tag);
    pe_req_ld = 1'b1;
    pe_req_addr = a;
    pe_req_d_or_tag = {$urandom, $urandom_range(0, 536870911), tag};
    n_push++;
  endtask

  task automatic wait_idle(input int max, input string name);
    int k = 0;
    tick();
    while (!idle && k < max) begin tick(); k++; end
    chk(name, idle, 1'b1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin : stim
    int base, k, ld5_cyc;
    bit seen;
    // reset
    tick(); tick();
    chk("reset idle", idle, 1'b1);
    chk("reset err", err, 1'b0);
    chk("reset mc_req_ld", mc_req_ld, 1'b0);
    chk("reset pe_req_stall", pe_req_stall, 1'b0);
    rst = 1'b0;
    tick();

    // 1: three loads answered in reverse order
    got_tag.delete(); got_q.delete();
    pe_load(48'h100, 3'd5); tick();
    pe_load(48'h208, 3'd1); tick();
    pe_load(48'h310, 3'd6); tick();
    k = 0;
    while (pend.size() < 3 && k < 20) begin tick(); k++; end
    chk("t1 loads issued", pend.size(), 3);
    if (pend.size() == 3) begin
      send(pend[2]); tick();
      send(pend[1]); tick();
      send(pend[0]);
      pend.delete();
    end
    k = 0;
    while (got_tag.size() < 3 && k < 30) begin tick(); k++; end
    chk("t1 rsp count", got_tag.size(), 3);
    if (got_tag.size() >= 3) begin
      chk("t1 tag0", got_tag[0], 3'd6);
      chk("t1 tag1", got_tag[1], 3'd1);
      chk("t1 tag2", got_tag[2], 3'd5);
      chk("t1 q0", got_q[0], 64'hBEEF_0000_0000_0310);
      chk("t1 q2", got_q[2], 64'hBEEF_0000_0000_0100);
    end
    wait_idle(50, "t1 idle");

    // 2: single store, two-cycle latency, idle held until WRCMP
    pe_req_st = 1'b1; pe_req_addr = 48'h1000; pe_req_d_or_tag = 64'hDEAD; n_push++;
    tick(); tick();
    chk("t2 mc_req_st", mc_req_st, 1'b1);
    chk("t2 vadr", mc_req_vadr, 48'h1000);
    chk("t2 wrd", mc_req_wrd_rdctl, 64'hDEAD);
    repeat (5) tick();
    chk("t2 idle before wrcmp", idle, 1'b0);
    if (pend.size() > 0) begin send(pend[0]); pend.delete(); end
    wait_idle(20, "t2 idle after wrcmp");

    // 3: credit limit with PE response stalled
    pe_rsp_stall = 1'b1;
    auto_rsp = 1;
    base = n_ld;
    for (int i = 0; i < 6; i++) begin
      pe_load(48'h4000 + 48'(i * 8), 3'(i));
      tick();
    end
    repeat (30) tick();
    chk("t3 loads under credit limit", n_ld - base, 4);
    chk("t3 mc_rsp_stall", mc_rsp_stall, 1'b1);
    first_rsp_cyc = -1;
    pe_rsp_stall = 1'b0;
    k = 0;
    while (n_ld - base < 5 && k < 30) begin tick(); k++; end
    ld5_cyc = last_ld_cyc;
    chk("t3 5th load after credit", ld5_cyc - first_rsp_cyc, 1);
    wait_idle(100, "t3 idle");

    // 4: request back-pressure with MC read queue stalled
    mc_rd_rq_stall = 1'b1;
    base = n_ld;
    n_push = 0;
    seen = 0;
    k = 0;
    while (n_push < 20 && k < 200) begin
      tick();
      k++;
      if (k == 40) begin
        chk("t4 nothing issued while stalled", n_ld - base, 0);
        mc_rd_rq_stall = 1'b0;
      end
      if (pe_req_stall && !seen) begin
        seen = 1;
        chk("t4 pushes at first stall", n_push, 13);
      end
      if (!pe_req_stall && n_push < 20) pe_load(48'h8000 + 48'(n_push * 8), 3'(n_push));
    end
    chk("t4 stall observed", seen, 1'b1);
    wait_idle(300, "t4 idle");
    chk("t4 all loads issued", n_ld - base, 20);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      tick();
      mc_rd_rq_stall = ($urandom_range(0, 3) == 0);
      mc_wr_rq_stall = ($urandom_range(0, 3) == 0);
      pe_rsp_stall   = ($urandom_range(0, 3) == 0);
      if (!pe_req_stall && $urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 1) == 0) pe_load({$urandom, 16'($urandom)}, 3'($urandom));
        else begin
          pe_req_st = 1'b1;
          pe_req_addr = {$urandom, 16'($urandom)};
          pe_req_d_or_tag = {$urandom, $urandom};
        end
      end
    end
    mc_rd_rq_stall = 1'b0; mc_wr_rq_stall = 1'b0; pe_rsp_stall = 1'b0;
    wait_idle(500, "random idle");
    chk("random err clear", err, 1'b0);

    // 5: ld+st collision, then reset with loads outstanding
    auto_rsp = 0;
    base = n_ld;
    k = n_st;
    pe_req_ld = 1'b1; pe_req_st = 1'b1;
    pe_req_addr = 48'h2000; pe_req_d_or_tag = 64'h1234_0005;
    tick();
    chk("t5 err set", err, 1'b1);
    repeat (4) tick();
    chk("t5 no load issued", n_ld - base, 0);
    chk("t5 store issued", n_st - k, 1);
    pe_load(48'h3000, 3'd2); tick();
    pe_load(48'h3008, 3'd3); tick();
    pe_load(48'h3010, 3'd4); tick();
    repeat (4) tick();
    chk("t5 loads outstanding", n_ld - base, 3);
    rst = 1'b1;
    if (pend.size() > 1) send(pend[1]);
    tick();
    rst = 1'b0;
    pend.delete();
    chk("t5 reset idle", idle, 1'b1);
    chk("t5 reset err", err, 1'b0);
    chk("t5 reset mc_req_ld", mc_req_ld, 1'b0);
    chk("t5 reset pe_rsp_push", pe_rsp_push, 1'b0);
    repeat (5) tick();
    chk("t5 idle after reset", idle, 1'b1);
    chk("t5 no stray rsp", pe_rsp_push, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
